lsu_bus_bridge: RTL and testbench
=================================

// Module: lsu_bus_bridge
// PURPOSE
//  Load/store unit between the single-cycle datapath's data port (dAddr, dWdata, dRdata) and a
//  32-bit word-addressed memory bus with req/ready handshake. Generates byte enables and lane-aligned
//  store data, sign/zero-extends load data, and stalls the core until the bus transfer completes.
//  Replaces the direct combinational RAM hookup so slow or wait-stated memories can be attached.
// PARAMETERS
//  TIMEOUT    16  max cycles in REQ waiting for bus_ready before aborting with bus_err (>=2)
// PORTS
//  clk        in   1   core clock, all state on rising edge
//  reset      in   1   asynchronous, active-low reset (0 = reset asserted)
//  mem_rd     in   1   current instruction is a load
//  mem_wr     in   1   current instruction is a store (mem_rd & mem_wr never both 1)
//  funct3     in   3   instr[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  dAddr      in   32  byte address from datapath ALU
//  dWdata     in   32  store data from register file rs2
//  dRdata     out  32  extended load data to datapath writeback mux
//  stall      out  1   1 = hold PC and suppress regfile write this cycle
//  misalign   out  1   1-cycle pulse: misaligned access detected, no bus activity
//  bus_err    out  1   1-cycle pulse: bus timeout, transfer aborted
//  bus_req    out  1   request valid; held until bus_ready sampled high
//  bus_we     out  1   1 = write
//  bus_addr   out  32  {addr[31:2],2'b00}
//  bus_be     out  4   byte enables, lane i = bits[8i+7:8i]
//  bus_wdata  out  32  lane-replicated store data
//  bus_ready  in   1   slave accepts/completes transfer this cycle
//  bus_rdata  in   32  read word, valid in the cycle bus_ready=1
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; all outputs 0; capture regs and timeout counter 0.
//  FSM: IDLE -> REQ -> DONE -> IDLE.
//   IDLE: if (mem_rd|mem_wr) and aligned: latch addr, we, funct3, be, wdata; stall=1 combinationally
//         this cycle; next state REQ. If misaligned: misalign=1, stall=0, dRdata=0, no REQ, stay IDLE.
//         If neither: stall=0, bus idle.
//   REQ:  bus_req=1 with registered addr/we/be/wdata, stable until ready; stall=1; count++.
//         bus_ready=1 -> capture bus_rdata (reads), -> DONE, count=0.
//         count reaches TIMEOUT-1 with no ready -> bus_err pulse in DONE cycle, captured data=0, -> DONE.
//   DONE: bus_req=0; stall=0; dRdata driven from capture reg (extended); core commits at this edge;
//         -> IDLE. Next instruction is evaluated in IDLE on the following cycle (no re-trigger).
//  Latency: zero-wait slave (ready in first REQ cycle) = 3 cycles per load/store (IDLE, REQ, DONE);
//  each wait state adds 1. Non-memory instructions: 0 stall cycles.
//  Alignment: H/HU need addr[0]=0; W needs addr[1:0]=0; B/BU always aligned.
//  Store: SB be=4'b0001<<addr[1:0], wdata={4{dWdata[7:0]}}; SH be=addr[1]?4'b1100:4'b0011,
//   wdata={2{dWdata[15:0]}}; SW be=4'b1111, wdata=dWdata. Loads: be=4'b1111, wdata=0.
//  Load extension from captured word w, lane by addr[1:0]: LB sign-ext w byte, LBU zero-ext byte,
//   LH/LHU halfword at addr[1], LW w. Undefined funct3 (011,110,111): treated as W for alignment/be,
//   dRdata = w.
//  dRdata outside DONE = 0. bus_ready while not in REQ is ignored.
//  Reset mid-transfer: FSM to IDLE immediately, bus_req drops asynchronously; slave must tolerate abort.
//  Timeout counter width = $clog2(TIMEOUT)+1; saturates, never wraps.
// TESTING
//  1 LW addr=0x100, slave ready in 1st REQ cycle, rdata=0xDEADBEEF -> bus_addr=0x100, be=1111,
//    stall high 2 cycles, DONE dRdata=0xDEADBEEF.
//  2 LB addr=0x103, rdata=0x80112233 -> be=1111, dRdata=0xFFFFFF80; LBU same -> 0x00000080;
//    LH addr=0x102 rdata=0x8001xxxx -> 0xFFFF8001.
//  3 SB addr=0x201 dWdata=0x000000AB -> bus_addr=0x200, be=0010, wdata=0xABABABAB, we=1;
//    SH addr=0x202 dWdata=0x1234 -> be=1100, wdata=0x12341234.
//  4 LW addr=0x102 -> misalign pulse 1 cycle, bus_req never 1, stall=0, dRdata=0.
//  5 slave holds ready=0 for 3 cycles then 1 -> bus_req/addr/be stable 4 cycles, stall 5 cycles;
//    ready never -> bus_err pulse after TIMEOUT=16 REQ cycles, dRdata=0, FSM back to IDLE.
//  6 reset=0 asserted in REQ -> bus_req, stall drop same cycle; after release, state IDLE, outputs 0.

Source files
------------

// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: datapath data port to req/ready word bus.
// Stalls the core while a load/store is on the bus.
module lsu_bus_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    output logic [31:0] dRdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        act;
    logic        aligned;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic [31:0] lane_sh;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] ext;

    // Decode size from funct3: alignment, byte enables, lane data.
    always_comb begin
        act     = (mem_rd | mem_wr) & reset;
        aligned = (dAddr[1:0] == 2'b00);
        be_n    = 4'b1111;
        wd_n    = dWdata;
        unique case (1'b1)
            (funct3[1:0] == 2'b00): begin
                aligned = 1'b1;
                be_n    = 4'b0001 << dAddr[1:0];
                wd_n    = {4{dWdata[7:0]}};
            end
            (funct3[1:0] == 2'b01): begin
                aligned = ~dAddr[0];
                be_n    = dAddr[1] ? 4'b1100 : 4'b0011;
                wd_n    = {2{dWdata[15:0]}};
            end
            default: begin
            end
        endcase
        if (!mem_wr) begin
            be_n = 4'b1111;
            wd_n = '0;
        end
    end

    // Next-state logic for the transfer FSM and capture registers.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        we_d    = we_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (act && aligned) begin
                    addr_d  = dAddr;
                    wdata_d = wd_n;
                    be_d    = be_n;
                    f3_d    = funct3;
                    we_d    = mem_wr;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus_ready) begin
                    rdata_d = we_q ? 32'h0 : bus_rdata;
                    cnt_d   = '0;
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Load extension from the captured word, selected by lane.
    always_comb begin
        lane_sh = rdata_q >> {addr_q[1:0], 3'b000};
        lb      = lane_sh[7:0];
        lh      = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        unique case (1'b1)
            (f3_q == 3'b000): ext = {{24{lb[7]}}, lb};
            (f3_q == 3'b100): ext = {24'h0, lb};
            (f3_q == 3'b001): ext = {{16{lh[15]}}, lh};
            (f3_q == 3'b101): ext = {16'h0, lh};
            default:          ext = rdata_q;
        endcase
    end

    // Core-side and bus-side outputs, quiet outside their states.
    always_comb begin
        bus_req   = (state_q == REQ);
        bus_we    = bus_req & we_q;
        bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
        bus_be    = bus_req ? be_q : 4'h0;
        bus_wdata = bus_req ? wdata_q : 32'h0;
        stall     = bus_req |
                    ((state_q == IDLE) & act & aligned);
        misalign  = (state_q == IDLE) & act & ~aligned;
        bus_err   = (state_q == DONE) & err_q;
        dRdata    = (state_q == DONE) ? ext : 32'h0;
    end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// tb_lsu_bus_bridge: directed checks of the LSU bus bridge.
// Each task drives one scenario and compares inline.
module tb_lsu_bus_bridge;

    logic        clk;
    logic        reset;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [31:0] dRdata;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    lsu_bus_bridge #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .funct3    (funct3),
        .dAddr     (dAddr),
        .dWdata    (dWdata),
        .dRdata    (dRdata),
        .stall     (stall),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one access and observe it; waits<0 means slave never ready.
    task automatic run_xfer(
        input  logic        rd,
        input  logic        wr,
        input  logic [2:0]  f3,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  logic [31:0] rdat,
        input  int          waits,
        output logic [31:0] o_addr,
        output logic [3:0]  o_be,
        output logic [31:0] o_wd,
        output logic        o_we,
        output logic        stable,
        output int          nst,
        output int          nreq,
        output logic [31:0] o_rd,
        output logic        o_err,
        output int          nerr
    );
        logic was_req;
        logic fin;
        @(posedge clk); #1;
        mem_rd = rd; mem_wr = wr; funct3 = f3;
        dAddr = a; dWdata = wd;
        bus_ready = 1'b0; bus_rdata = 32'h0;
        o_addr = 'x; o_be = 'x; o_wd = 'x; o_we = 'x;
        o_rd = 'x; o_err = 'x;
        stable = 1'b1; nst = 0; nreq = 0; nerr = 0;
        was_req = 1'b0; fin = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk);
            if (stall) nst++;
            if (bus_err) nerr++;
            if (bus_req) begin
                if (nreq == 0) begin
                    o_addr = bus_addr; o_be = bus_be;
                    o_wd = bus_wdata; o_we = bus_we;
                end else if (bus_addr !== o_addr || bus_be !== o_be ||
                             bus_wdata !== o_wd || bus_we !== o_we) begin
                    stable = 1'b0;
                end
                if (nreq == waits) begin
                    bus_ready = 1'b1; bus_rdata = rdat;
                end else begin
                    bus_ready = 1'b0; bus_rdata = 32'h5A5A5A5A;
                end
                nreq++;
                was_req = 1'b1;
            end else if (was_req) begin
                o_rd = dRdata; o_err = bus_err;
                bus_ready = 1'b0;
                fin = 1'b1;
            end
        end
        @(posedge clk); #1;
        mem_rd = 1'b0; mem_wr = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        if (bus_err) nerr++;
    endtask

    task automatic test_reset;
        #2;
        total_cnt++;
        if ({bus_req, bus_we, stall, misalign, bus_err} !== 5'b0)
            $display("FAIL rst_ctl got %b exp 00000",
                     {bus_req, bus_we, stall, misalign, bus_err});
        else pass_cnt++;
        total_cnt++;
        if ({dRdata, bus_addr, bus_wdata, bus_be} !== 100'h0)
            $display("FAIL rst_data got %h exp 0",
                     {dRdata, bus_addr, bus_wdata, bus_be});
        else pass_cnt++;
        mem_rd = 1'b1; funct3 = 3'b010; dAddr = 32'h100;
        #1;
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", stall);
        else pass_cnt++;
        mem_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_lw;
        logic [31:0] ad, wd, rdv; logic [3:0] be; logic we, st, er;
        int ns, nr, ne;
        run_xfer(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0,
                 ad, be, wd, we, st, ns, nr, rdv, er, ne);
        total_cnt++;
        if (ad !== 32'h100) $display("FAIL lw_addr got %h exp 100", ad);
        else pass_cnt++;
        total_cnt++;
        if ({be, we} !== 5'b11110) $display("FAIL lw_be_we got %b exp 11110", {be, we});
        else pass_cnt++;
        total_cnt++;
        if (ns !== 2 || nr !== 1)
            $display("FAIL lw_lat got stall=%0d req=%0d exp 2/1", ns, nr);
        else pass_cnt++;
        total_cnt++;
        if (rdv !== 32'hDEADBEEF) $display("FAIL lw_data got %h exp deadbeef", rdv);
        else pass_cnt++;
        total_cnt++;
        if (ne !== 0) $display("FAIL lw_err got %0d exp 0", ne);
        else pass_cnt++;
    endtask

    task automatic test_load_ext;
        logic [31:0] ad, wd, rdv; logic [3:0] be; logic we, st, er;
        int ns, nr, ne;
        logic [2:0]  f3 [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b011};
        logic [31:0] av [7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100, 32'h104};
        logic [31:0] rv [7] = '{32'h80112233, 32'h80112233, 32'h80015555, 32'h80015555,
                                32'h80112233, 32'h80119233, 32'hCAFEF00D};
        logic [31:0] ev [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001,
                                32'h00000033, 32'hFFFF9233, 32'hCAFEF00D};
        for (int i = 0; i < 7; i++) begin
            run_xfer(1'b1, 1'b0, f3[i], av[i], 32'h0, rv[i], 0,
                     ad, be, wd, we, st, ns, nr, rdv, er, ne);
            total_cnt++;
            if (rdv !== ev[i] || be !== 4'b1111)
                $display("FAIL ld_ext%0d got %h be=%b exp %h be=1111", i, rdv, be, ev[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_store;
        logic [31:0] ad, wd, rdv; logic [3:0] be; logic we, st, er;
        int ns, nr, ne;
        logic [2:0]  f3 [4] = '{3'b000, 3'b001, 3'b010, 3'b000};
        logic [31:0] av [4] = '{32'h201, 32'h202, 32'h300, 32'h203};
        logic [31:0] dv [4] = '{32'h000000AB, 32'h00001234, 32'h89ABCDEF, 32'h11223344};
        logic [31:0] ea [4] = '{32'h200, 32'h200, 32'h300, 32'h200};
        logic [3:0]  eb [4] = '{4'b0010, 4'b1100, 4'b1111, 4'b1000};
        logic [31:0] ew [4] = '{32'hABABABAB, 32'h12341234, 32'h89ABCDEF, 32'h44444444};
        for (int i = 0; i < 4; i++) begin
            run_xfer(1'b0, 1'b1, f3[i], av[i], dv[i], 32'hFFFFFFFF, 0,
                     ad, be, wd, we, st, ns, nr, rdv, er, ne);
            total_cnt++;
            if (ad !== ea[i] || be !== eb[i] || wd !== ew[i] || we !== 1'b1)
                $display("FAIL st%0d got a=%h be=%b wd=%h we=%b exp a=%h be=%b wd=%h we=1",
                         i, ad, be, wd, we, ea[i], eb[i], ew[i]);
            else pass_cnt++;
            total_cnt++;
            if (ns !== 2) $display("FAIL st%0d_stall got %0d exp 2", i, ns);
            else pass_cnt++;
        end
    endtask

    task automatic test_misalign;
        logic [2:0]  f3 [3] = '{3'b010, 3'b001, 3'b101};
        logic [31:0] av [3] = '{32'h102, 32'h203, 32'h101};
        logic        wr [3] = '{1'b0, 1'b1, 1'b0};
        logic        bad;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mem_rd = ~wr[i]; mem_wr = wr[i]; funct3 = f3[i];
            dAddr = av[i]; dWdata = 32'h12345678;
            @(negedge clk);
            total_cnt++;
            if ({misalign, stall, bus_req} !== 3'b100 || dRdata !== 32'h0)
                $display("FAIL mis%0d got mis/stall/req=%b d=%h exp 100 d=0",
                         i, {misalign, stall, bus_req}, dRdata);
            else pass_cnt++;
            @(posedge clk); #1;
            mem_rd = 1'b0; mem_wr = 1'b0;
            bad = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (misalign || bus_req || stall) bad = 1'b1;
            end
            total_cnt++;
            if (bad !== 1'b0) $display("FAIL mis%0d_after got 1 exp 0", i);
            else pass_cnt++;
        end
    endtask

    task automatic test_wait_timeout;
        logic [31:0] ad, wd, rdv; logic [3:0] be; logic we, st, er;
        int ns, nr, ne;
        run_xfer(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0BADF00D, 3,
                 ad, be, wd, we, st, ns, nr, rdv, er, ne);
        total_cnt++;
        if (ns !== 5 || nr !== 4 || st !== 1'b1)
            $display("FAIL wait3 got stall=%0d req=%0d stable=%b exp 5/4/1", ns, nr, st);
        else pass_cnt++;
        total_cnt++;
        if (rdv !== 32'h0BADF00D || ne !== 0)
            $display("FAIL wait3_data got %h err=%0d exp 0badf00d/0", rdv, ne);
        else pass_cnt++;
        run_xfer(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h11111111, -1,
                 ad, be, wd, we, st, ns, nr, rdv, er, ne);
        total_cnt++;
        if (nr !== 16 || ns !== 17)
            $display("FAIL tmo_len got req=%0d stall=%0d exp 16/17", nr, ns);
        else pass_cnt++;
        total_cnt++;
        if (er !== 1'b1 || ne !== 1 || rdv !== 32'h0)
            $display("FAIL tmo_err got err=%b pulses=%0d d=%h exp 1/1/0", er, ne, rdv);
        else pass_cnt++;
        total_cnt++;
        if ({bus_req, stall, bus_err} !== 3'b000)
            $display("FAIL tmo_idle got %b exp 000", {bus_req, stall, bus_err});
        else pass_cnt++;
    endtask

    task automatic test_idle_ready;
        logic bad;
        @(posedge clk); #1;
        mem_rd = 1'b0; mem_wr = 1'b0; dAddr = 32'h700;
        bus_ready = 1'b1; bus_rdata = 32'hFFFFFFFF;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus_req || stall || dRdata !== 32'h0 || bus_err) bad = 1'b1;
        end
        bus_ready = 1'b0;
        total_cnt++;
        if (bad !== 1'b0) $display("FAIL idle_ready got 1 exp 0");
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] ad, wd, rdv; logic [3:0] be; logic we, st, er;
        int ns, nr, ne;
        @(posedge clk); #1;
        mem_rd = 1'b1; funct3 = 3'b010; dAddr = 32'h400; bus_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (bus_req !== 1'b1) $display("FAIL rmid_req got %b exp 1", bus_req);
        else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if ({bus_req, stall} !== 2'b00)
            $display("FAIL rmid_drop got %b exp 00", {bus_req, stall});
        else pass_cnt++;
        mem_rd = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({bus_req, stall, bus_err, misalign} !== 4'b0 ||
            {bus_addr, bus_be, dRdata} !== 68'h0)
            $display("FAIL rmid_after got ctl=%b a=%h be=%b d=%h exp 0",
                     {bus_req, stall, bus_err, misalign}, bus_addr, bus_be, dRdata);
        else pass_cnt++;
        run_xfer(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 32'h76543210, 0,
                 ad, be, wd, we, st, ns, nr, rdv, er, ne);
        total_cnt++;
        if (ns !== 2 || rdv !== 32'h76543210 || ad !== 32'h404)
            $display("FAIL rmid_xfer got stall=%0d d=%h a=%h exp 2/76543210/404",
                     ns, rdv, ad);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b000;
        dAddr = 32'h0; dWdata = 32'h0;
        bus_ready = 1'b0; bus_rdata = 32'h0;
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_misalign();
        test_wait_timeout();
        test_idle_ready();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
